// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU CPU-side VRAM access port.
// Holds the $2007 access FSM state type, the register index map, the
// VRAM address increment steps and the CIRAM mirroring / palette alias
// helpers used by vram_access_port and palette_ram.
package ppu_pkg;

    // $2007 access sequencer: one idle state, one CIRAM access cycle.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } acc_state_e;

    // CPU register indices ($2000 + index).
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    // VRAM address step after each $2007 access (PPUCTRL bit 2).
    localparam logic [13:0] INC_ACROSS = 14'd1;
    localparam logic [13:0] INC_DOWN   = 14'd32;

    // Upper address bits of the palette window $3F00-$3FFF.
    localparam logic [5:0] PAL_PAGE = 6'h3F;

    // Fold a 14-bit PPU address onto the 2 KiB CIRAM. Address bits 11:10
    // select one of four logical nametables; the mirroring bit decides
    // which of the two picks the physical 1 KiB bank. $3000-$3EFF falls
    // out naturally because bit 12 is ignored.
    function automatic logic [10:0] fold_nt(input logic [13:0] v, input logic mirror_v);
        logic [10:0] a;
        if (mirror_v) begin
            a = {v[10], v[9:0]};
        end else begin
            a = {v[11], v[9:0]};
        end
        return a;
    endfunction

    // Sprite palette entry 0 of each group ($3F10/$14/$18/$1C) shares its
    // storage with the matching background entry ($3F00/$04/$08/$0C).
    function automatic logic [4:0] pal_alias(input logic [4:0] idx);
        logic [4:0] r;
        if (idx[1:0] == 2'b00) begin
            r = {1'b0, idx[3:0]};
        end else begin
            r = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// palette_ram: 32 x 6-bit PPU palette storage with aliased sprite
// backdrop entries. One synchronous write port (CPU $2007 writes) and two
// combinational read ports: one for the CPU $2007 read path and one for
// the renderer. Only instantiated when VRAM_PALETTE_EN is defined.
module palette_ram
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [5:0] wdata,
    input  logic [4:0] cpu_raddr,
    output logic [5:0] cpu_rdata,
    input  logic [4:0] ren_raddr,
    output logic [5:0] ren_rdata
);

    logic [5:0] mem_r [32];

    // Palette storage; aliased indices collapse onto their background slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= 6'h00;
            end
        end else if (we) begin
            mem_r[pal_alias(waddr)] <= wdata;
        end
    end

    // Both read ports are asynchronous and apply the same alias decode.
    always_comb begin
        cpu_rdata = mem_r[pal_alias(cpu_raddr)];
        ren_rdata = mem_r[pal_alias(ren_raddr)];
    end

endmodule

// File: rtl/vram_access_port.sv
// vram_access_port: CPU-side VRAM access port of the PPU.
// Implements the PPUCTRL increment bit, the PPUADDR two-write latch and
// the buffered PPUDATA ($2007) path onto the 2 KiB CIRAM, whose
// address/WE/data pins are driven directly from registers.
// Build option: define VRAM_PALETTE_EN to add internal palette RAM at
// $3F00-$3FFF and the pal_raddr/pal_rdata renderer port. Without it the
// palette window is just another nametable mirror.
module vram_access_port
    import ppu_pkg::*;
#(
    parameter int AW = 14,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [2:0]    cpu_reg,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_dout_valid,
    output logic          ready,
    input  logic          mirror_v,
    output logic [CW-1:0] ciram_addr,
    output logic          ciram_we,
    output logic [7:0]    ciram_din,
    input  logic [7:0]    ciram_dout
`ifdef VRAM_PALETTE_EN
    ,
    input  logic [4:0]    pal_raddr,
    output logic [5:0]    pal_rdata
`endif
);

    // Architectural state
    acc_state_e    state_r;
    logic [AW-1:0] v_r;
    logic [AW-1:0] t_r;
    logic          w_r;
    logic          inc32_r;
    logic [7:0]    rd_buf_r;
    logic          pend_we_r;
    logic [7:0]    pend_din_r;

    // Output registers
    logic [7:0]    cpu_dout_r;
    logic          cpu_dout_valid_r;
    logic          ready_r;
    logic [CW-1:0] ciram_addr_r;
    logic          ciram_we_r;

    // Decoded strobes and address classification
    logic          strobe_s;
    logic          ctrl_wr_s;
    logic          status_rd_s;
    logic          addr_wr_s;
    logic          data_go_s;
    logic          access_s;
    logic          nt_region_s;
    logic          pal_region_s;
    logic [CW-1:0] fold_s;
    logic [AW-1:0] step_s;
    logic [7:0]    rd_data_s;
    logic [7:0]    refill_s;

`ifdef VRAM_PALETTE_EN
    logic          pal_we_s;
    logic [5:0]    pal_cpu_rdata_s;
`endif

    // Register strobe decode; anything arriving while busy is ignored.
    always_comb begin
        strobe_s    = cpu_cs & ready_r;
        ctrl_wr_s   = 1'b0;
        status_rd_s = 1'b0;
        addr_wr_s   = 1'b0;
        data_go_s   = 1'b0;
        if (strobe_s) begin
            case (cpu_reg)
                REG_CTRL:   ctrl_wr_s   = cpu_we;
                REG_STATUS: status_rd_s = ~cpu_we;
                REG_ADDR:   addr_wr_s   = cpu_we;
                REG_DATA:   data_go_s   = (state_r == ST_IDLE);
                default:    data_go_s   = 1'b0;
            endcase
        end else begin
            data_go_s = 1'b0;
        end
    end

    // Classify the current VRAM address and prepare the access datapath.
    always_comb begin
        access_s = (state_r == ST_ACCESS);
`ifdef VRAM_PALETTE_EN
        pal_region_s = (v_r[AW-1:8] == PAL_PAGE);
`else
        pal_region_s = 1'b0;
`endif
        // $2000-$3FFF minus the palette window (when present).
        nt_region_s = v_r[AW-1] & ~pal_region_s;
        // Palette reads refill from fold(v - $1000); bits 11:0 are
        // unchanged by that subtraction, so the same fold applies.
        fold_s      = fold_nt(v_r, mirror_v);
        if (inc32_r) begin
            step_s = INC_DOWN;
        end else begin
            step_s = INC_ACROSS;
        end
`ifdef VRAM_PALETTE_EN
        if (pal_region_s) begin
            rd_data_s = {2'b00, pal_cpu_rdata_s};
        end else begin
            rd_data_s = rd_buf_r;
        end
`else
        rd_data_s = rd_buf_r;
`endif
        // CHR space has no backing store here, so the buffer reads back zero.
        if (nt_region_s | pal_region_s) begin
            refill_s = ciram_dout;
        end else begin
            refill_s = 8'h00;
        end
    end

    // PPUCTRL increment bit, PPUADDR latch and the v/t address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_r     <= '0;
            t_r     <= '0;
            w_r     <= 1'b0;
            inc32_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                inc32_r <= cpu_din[2];
            end
            if (status_rd_s) begin
                w_r <= 1'b0;
            end else if (addr_wr_s) begin
                if (!w_r) begin
                    t_r[AW-1:8] <= cpu_din[AW-9:0];
                    w_r         <= 1'b1;
                end else begin
                    t_r[7:0]    <= cpu_din;
                    v_r         <= {t_r[AW-1:8], cpu_din};
                    w_r         <= 1'b0;
                end
            end
            // ADDR writes cannot coincide with this: ready is low in ACCESS.
            if (access_s) begin
                v_r <= v_r + step_s;
            end
        end
    end

    // $2007 sequencer: accept a strobe in IDLE, spend one cycle in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            pend_we_r  <= 1'b0;
            pend_din_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (data_go_s) begin
                        state_r    <= ST_ACCESS;
                        ready_r    <= 1'b0;
                        pend_we_r  <= cpu_we;
                        pend_din_r <= cpu_din;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // CIRAM pins: address and WE are set up at the strobe edge so the
    // RAM sees a stable access at the following negedge; WE lasts one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ciram_addr_r <= '0;
            ciram_we_r   <= 1'b0;
        end else if (data_go_s) begin
            ciram_addr_r <= fold_s;
            ciram_we_r   <= cpu_we & nt_region_s;
        end else begin
            ciram_we_r   <= 1'b0;
        end
    end

    // Read return: hand out the old buffer (or palette data) and refill it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_dout_r       <= 8'h00;
            cpu_dout_valid_r <= 1'b0;
            rd_buf_r         <= 8'h00;
        end else if (access_s && !pend_we_r) begin
            cpu_dout_r       <= rd_data_s;
            cpu_dout_valid_r <= 1'b1;
            rd_buf_r         <= refill_s;
        end else begin
            cpu_dout_valid_r <= 1'b0;
        end
    end

`ifdef VRAM_PALETTE_EN
    // Palette writes commit at the end of the access cycle.
    always_comb begin
        pal_we_s = access_s & pend_we_r & pal_region_s;
    end

    palette_ram u_palette_ram (
        .clk       (clk),
        .rst       (reset),
        .we        (pal_we_s),
        .waddr     (v_r[4:0]),
        .wdata     (pend_din_r[5:0]),
        .cpu_raddr (v_r[4:0]),
        .cpu_rdata (pal_cpu_rdata_s),
        .ren_raddr (pal_raddr),
        .ren_rdata (pal_rdata)
    );
`endif

    assign cpu_dout       = cpu_dout_r;
    assign cpu_dout_valid = cpu_dout_valid_r;
    assign ready          = ready_r;
    assign ciram_addr     = ciram_addr_r;
    assign ciram_we       = ciram_we_r;
    // The pending write data register is the CIRAM data pin.
    assign ciram_din      = pend_din_r;

endmodule

// File: tb/tb_vram_access_port.sv
// tb_vram_access_port: directed bench for vram_access_port with a
// behavioural CIRAM, an address-level reference model of the port and a
// per-cycle compare process. Works with or without VRAM_PALETTE_EN.
module tb_vram_access_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_reg = 3'd0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_valid;
    logic        ready;
    logic        mirror_v = 1'b1;
    logic [10:0] ciram_addr;
    logic        ciram_we;
    logic [7:0]  ciram_din;
    logic [7:0]  ciram_dout;
`ifdef VRAM_PALETTE_EN
    logic [4:0]  pal_raddr = 5'd0;
    logic [5:0]  pal_rdata;
`endif

    vram_access_port dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_cs         (cpu_cs),
        .cpu_we         (cpu_we),
        .cpu_reg        (cpu_reg),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .cpu_dout_valid (cpu_dout_valid),
        .ready          (ready),
        .mirror_v       (mirror_v),
        .ciram_addr     (ciram_addr),
        .ciram_we       (ciram_we),
        .ciram_din      (ciram_din),
        .ciram_dout     (ciram_dout)
`ifdef VRAM_PALETTE_EN
        ,
        .pal_raddr      (pal_raddr),
        .pal_rdata      (pal_rdata)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural CIRAM: samples address/WE/data on the falling edge.
    logic [7:0] ciram_mem [2048];
    always @(negedge clk) begin
        if (ciram_we) ciram_mem[ciram_addr] <= ciram_din;
        ciram_dout <= ciram_mem[ciram_addr];
    end

    // Counters
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (plain integers / arrays)
    int         m_v = 0, m_t = 0, m_w = 0, m_inc32 = 0;
    logic [7:0] m_buf = 8'h00;
    logic [7:0] m_nt [2048];
    logic [5:0] m_pal [32];

    // Per-cycle expectations driven by the stimulus tasks
    bit          chk_en = 1'b0;
    bit          exp_ready = 1'b1, exp_we = 1'b0, exp_valid = 1'b0, exp_addr_chk = 1'b0;
    logic [7:0]  exp_dout = 8'h00, exp_din = 8'h00;
    logic [10:0] exp_addr = 11'h000;

    function automatic int m_fold(input int v);
        int a, page, sel;
        a    = v % 4096;
        page = a / 1024;
        sel  = mirror_v ? (page % 2) : (page / 2);
        return sel * 1024 + (a % 1024);
    endfunction

    function automatic bit m_is_pal(input int v);
`ifdef VRAM_PALETTE_EN
        return v >= 'h3F00;
`else
        return (v < 0);
`endif
    endfunction

    function automatic bit m_is_nt(input int v);
        return (v >= 'h2000) && !m_is_pal(v);
    endfunction

    function automatic int m_pidx(input int v);
        int i;
        i = v % 32;
        if (i >= 16 && (i % 4) == 0) i = i - 16;
        return i;
    endfunction

    // Compare process: outputs checked mid-cycle against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(ready), 32'(exp_ready));
            check("ciram_we", 32'(ciram_we), 32'(exp_we));
            check("dout_valid", 32'(cpu_dout_valid), 32'(exp_valid));
            if (exp_valid)    check("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
            if (exp_addr_chk) check("ciram_addr", 32'(ciram_addr), 32'(exp_addr));
            if (exp_we)       check("ciram_din", 32'(ciram_din), 32'(exp_din));
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic reg_access(input logic [2:0] r, input logic we, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_reg = r; cpu_we = we; cpu_din = d;
        step();
        cpu_cs = 1'b0;
        if (r == 3'd0 && we) begin
            m_inc32 = int'(d[2]);
        end else if (r == 3'd2 && !we) begin
            m_w = 0;
        end else if (r == 3'd6 && we) begin
            if (m_w == 0) begin
                m_t = int'(d[5:0]) * 256 + (m_t % 256);
                m_w = 1;
            end else begin
                m_t = (m_t / 256) * 256 + int'(d);
                m_v = m_t;
                m_w = 0;
            end
        end
    endtask

    task automatic set_v(input logic [13:0] a);
        reg_access(3'd2, 1'b0, 8'h00);
        reg_access(3'd6, 1'b1, {2'b00, a[13:8]});
        reg_access(3'd6, 1'b1, a[7:0]);
    endtask

    task automatic data(input logic we, input logic [7:0] d, input bit stuff,
                        output logic [10:0] c_addr, output logic c_we, output logic [7:0] c_din,
                        output logic [7:0] c_dout, output logic c_valid);
        bit nt, pal;
        int fa, pi;
        nt  = m_is_nt(m_v);
        pal = m_is_pal(m_v);
        fa  = pal ? m_fold(m_v - 'h1000) : m_fold(m_v);
        pi  = m_pidx(m_v);
        cpu_cs = 1'b1; cpu_reg = 3'd7; cpu_we = we; cpu_din = d;
        step();
        if (stuff) begin
            cpu_cs = 1'b1; cpu_reg = 3'd7; cpu_we = 1'b1; cpu_din = 8'hEE;
        end else begin
            cpu_cs = 1'b0;
        end
        exp_ready = 1'b0; exp_we = we && nt; exp_din = d;
        exp_addr = 11'(fa); exp_addr_chk = nt || pal;
        #2;
        c_addr = ciram_addr; c_we = ciram_we; c_din = ciram_din;
        step();
        cpu_cs = 1'b0;
        exp_ready = 1'b1; exp_we = 1'b0; exp_addr_chk = 1'b0;
        if (!we) begin
            exp_valid = 1'b1;
            exp_dout  = pal ? {2'b00, m_pal[pi]} : m_buf;
            m_buf     = (nt || pal) ? m_nt[fa] : 8'h00;
        end else begin
            if (nt)  m_nt[fa]  = d;
            if (pal) m_pal[pi] = d[5:0];
        end
        m_v = (m_v + (m_inc32 != 0 ? 32 : 1)) % 16384;
        c_dout = cpu_dout; c_valid = cpu_dout_valid;
    endtask

    logic [10:0] ca;
    logic        cw, cv;
    logic [7:0]  cd, co;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ciram_mem[i] = 8'(i) ^ 8'h5A;
            m_nt[i]      = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < 32; i++) m_pal[i] = 6'h00;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_dout", 32'(cpu_dout), 32'h0);
        check("rst_valid", 32'(cpu_dout_valid), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_addr", 32'(ciram_addr), 32'h0);
        check("rst_we", 32'(ciram_we), 32'h0);
        check("rst_din", 32'(ciram_din), 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Vertical write via two ADDR writes, then read back the next address
        mirror_v = 1'b1;
        reg_access(3'd6, 1'b1, 8'h21);
        reg_access(3'd6, 1'b1, 8'h08);
        data(1'b1, 8'hAB, 1'b0, ca, cw, cd, co, cv);
        check("t1_addr", 32'(ca), 32'h108);
        check("t1_we", 32'(cw), 32'h1);
        check("t1_din", 32'(cd), 32'hAB);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t1_v2109_addr", 32'(ca), 32'h109);
        check("t1_first_read", 32'(co), 32'h00);

        // Horizontal mirroring and buffered read
        mirror_v = 1'b0;
        set_v(14'h2C05);
        data(1'b1, 8'h55, 1'b0, ca, cw, cd, co, cv);
        check("t2_addr", 32'(ca), 32'h405);
        set_v(14'h2805);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t2_stale", 32'(co), 32'h53);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t2_second", 32'(co), 32'h55);
        check("t2_valid", 32'(cv), 32'h1);

        // Increment by 32 with wrap into CHR space
        mirror_v = 1'b1;
        reg_access(3'd0, 1'b1, 8'h04);
        set_v(14'h3FF0);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t3_addr", 32'(ca), 32'h7F0);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t3_chr_refill", 32'(co), 32'h00);
        data(1'b1, 8'h77, 1'b0, ca, cw, cd, co, cv);
        check("t3_chr_wr_dropped", 32'(cw), 32'h0);
        reg_access(3'd0, 1'b1, 8'h00);

        // STATUS read resets the ADDR latch
        reg_access(3'd6, 1'b1, 8'h10);
        reg_access(3'd2, 1'b0, 8'h00);
        reg_access(3'd6, 1'b1, 8'h23);
        reg_access(3'd6, 1'b1, 8'hC0);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t4_v23c0", 32'(ca), 32'h3C0);

        // Strobe while busy is dropped
        set_v(14'h2200);
        data(1'b1, 8'h11, 1'b1, ca, cw, cd, co, cv);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t5_no_extra_inc", 32'(ca), 32'h201);
        set_v(14'h2200);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t5_kept_data", 32'(co), 32'h11);

`ifdef VRAM_PALETTE_EN
        // Palette write through alias, immediate read
        set_v(14'h3F10);
        data(1'b1, 8'h2A, 1'b0, ca, cw, cd, co, cv);
        check("t6_pal_no_ciram_we", 32'(cw), 32'h0);
        set_v(14'h3F00);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t6_pal_dout", 32'(co), 32'h2A);
        check("t6_pal_valid", 32'(cv), 32'h1);
        check("t6_pal_rdata", 32'(pal_rdata), 32'h2A);
`endif

        // Reset in the middle of an access
        set_v(14'h2400);
        cpu_cs = 1'b1; cpu_reg = 3'd7; cpu_we = 1'b1; cpu_din = 8'h99;
        @(posedge clk); #1;
        cpu_cs = 1'b0;
        exp_valid = 1'b0;
        check("t7_we_before_rst", 32'(ciram_we), 32'h1);
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("t7_rst_dout", 32'(cpu_dout), 32'h0);
        check("t7_rst_valid", 32'(cpu_dout_valid), 32'h0);
        check("t7_rst_ready", 32'(ready), 32'h1);
        check("t7_rst_addr", 32'(ciram_addr), 32'h0);
        check("t7_rst_we", 32'(ciram_we), 32'h0);
        check("t7_rst_din", 32'(ciram_din), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_v = 0; m_t = 0; m_w = 0; m_inc32 = 0; m_buf = 8'h00;
        exp_ready = 1'b1; exp_we = 1'b0; exp_valid = 1'b0; exp_addr_chk = 1'b0;
        chk_en = 1'b1;
        set_v(14'h2400);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t7_buf_cleared", 32'(co), 32'h00);
        data(1'b0, 8'h00, 1'b0, ca, cw, cd, co, cv);
        check("t7_write_aborted", 32'(co), 32'h5A);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
